dnn_result_writer: RTL and testbench
====================================

# dnn_result_writer

Downstream stage of the detection pipeline wrapper: consumes the 512-bit `dnn_results` lines it produces and writes them, one cache line per result, to host memory at consecutive line addresses starting from a programmed base. A small FIFO decouples the pipeline from write-channel back-pressure. The block tracks write acknowledgements and raises a single-cycle `done` once the programmed number of results is committed.

## Interface

Parameters:
- `FIFO_DEPTH`, 4: result-line buffer depth; power of two, at least 2.
- `ADDR_W`, 42: host cache-line address width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches `base_addr` and `num_results`; ignored unless IDLE.
- `base_addr`  in  ADDR_W  line address of the first result.
- `num_results`  in  32  number of result lines to write.
- `dnn_results_vld`  in  1  pipeline presents a result line this cycle.
- `dnn_results`  in  512  result line.
- `results_acceptable`  out  1  writer accepts `dnn_results` this cycle.
- `wr_req`  out  1  write request valid; exactly one cycle per line.
- `wr_addr`  out  ADDR_W  line address of the request.
- `wr_data`  out  512  line data of the request.
- `wr_almost_full`  in  1  write channel back-pressure; no `wr_req` while high.
- `wr_ack`  in  1  one write completion; at most one per cycle.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when all writes are acknowledged.
- `wr_count`  out  32  acknowledged writes in the current job.

## Operation

- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on `start` when `num_results` != 0. Clears all counters and the FIFO.
  - IDLE -> DONE on `start` when `num_results` == 0.
  - RUN -> DRAIN when accepted == `num_results`.
  - DRAIN -> DONE when acked == `num_results`.
  - DONE -> IDLE unconditionally after one cycle; `done` is high only while in DONE.
- Accept: `results_acceptable` = (state == RUN) && (fifo_count < FIFO_DEPTH) && (accepted < `num_results`). It is computed from registered state only; a same-cycle pop does not free a slot.
  - A beat is taken when `dnn_results_vld` && `results_acceptable`. The beat is pushed and `accepted` increments.
  - `dnn_results_vld` while `results_acceptable` is low is not consumed. The pipeline holds the data.
- Issue: in RUN or DRAIN, when the FIFO is non-empty and `wr_almost_full` is low:
  - pop the FIFO head;
  - register `wr_req` = 1, `wr_data` = head, `wr_addr` = latched base + `issued` (modulo 2^ADDR_W; the address wraps silently);
  - increment `issued`.
- `wr_req` never stays high for two consecutive cycles carrying the same line.
- Ack: each `wr_ack` increments `acked` (exposed as `wr_count`). An ack arriving while acked == issued is a protocol violation and is ignored; the counter does not move.
- Simultaneous push and pop in the same cycle is legal: `fifo_count` is unchanged and order is preserved.
- `start` in RUN, DRAIN or DONE is ignored. The latched parameters stay stable for the whole job.
- `rst` at any time, including mid-job:
  - state goes to IDLE;
  - FIFO is emptied;
  - counters clear;
  - outstanding writes are forgotten; later `wr_ack`s while in IDLE are ignored.

## Timing

- Reset values: `results_acceptable` 0, `wr_req` 0, `wr_addr` 0, `wr_data` 0, `busy` 0, `done` 0, `wr_count` 0.
- `start` sampled at edge S:
  - state is RUN from S+1;
  - `busy` and `results_acceptable` are high in the cycle after S.
- Beat accepted at edge N with the FIFO empty and `wr_almost_full` low: `wr_req` is high in the cycle after edge N+1. Minimum latency is 2 cycles.
- Throughput: one line per cycle sustained while `wr_almost_full` is low and the pipeline is streaming.
- `wr_almost_full` sampled high at edge E: no `wr_req` in the cycle after E.
- Last ack sampled at edge A:
  - DONE in the cycle after A, with `done` = 1 for one cycle;
  - IDLE the following cycle, with `busy` = 0 from the DONE cycle.

## Test plan

- **Basic:** base 0x100, `num_results` 3, three back-to-back beats, immediate acks -> `wr_req` at addresses 0x100, 0x101, 0x102 with matching data in order; `done` one cycle; `wr_count` = 3.
- **Back-pressure:** `num_results` 8, `wr_almost_full` held high for 20 cycles, pipeline streaming -> exactly 4 beats accepted, `results_acceptable` low after that, no `wr_req` during the hold; after release, 8 writes complete in order.
- **Zero length:** `start` with `num_results` 0 -> `done` in the cycle after `start`, no `wr_req`, `results_acceptable` never high.
- **Wrap and excess input:** base 2^42−1, `num_results` 2 -> addresses 0x3FF_FFFF_FFFF then 0; a third `dnn_results_vld` is not accepted.
- **Reset mid-job:** `rst` after 2 of 5 writes issued -> all outputs at reset values next cycle; stray `wr_ack` ignored; a new `start` runs cleanly with `wr_count` starting at 0.
- **Protocol edge cases:** `start` pulse during RUN ignored; spurious `wr_ack` with nothing outstanding does not change `wr_count`.

Source files
------------

// File: rtl/dnn_result_writer.sv
// dnn_result_writer
//   Takes 512-bit result lines from the detection pipeline and writes each one
//   to host memory. The writes go to consecutive cache-line addresses that
//   start at a programmed base. A small FIFO absorbs write-channel back-pressure.
//   The block counts write acknowledgements and pulses done once the whole job
//   is committed.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle job start (IDLE only); latches base_addr/num_results
//   base_addr           line address of the first result
//   num_results         number of result lines in the job
//   dnn_results_vld     pipeline presents dnn_results this cycle
//   dnn_results         512-bit result line
//   results_acceptable  beat is consumed when dnn_results_vld is also high
//   wr_req/addr/data    registered write request, one cycle per line
//   wr_almost_full      write channel back-pressure, blocks issue
//   wr_ack              one write completion per cycle at most
//   busy                job in RUN or DRAIN
//   done                one-cycle pulse when every write is acknowledged
//   wr_count            acknowledged writes in the current job
module dnn_result_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 42
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       num_results,
  input  logic              dnn_results_vld,
  input  logic [511:0]      dnn_results,
  output logic              results_acceptable,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [511:0]      wr_data,
  input  logic              wr_almost_full,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic [31:0]       wr_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       num_q;
  logic [31:0]       accepted_q, accepted_d;
  logic [31:0]       issued_q,   issued_d;
  logic [31:0]       acked_q,    acked_d;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [511:0]      mem_q [FIFO_DEPTH];

  logic              wr_req_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [511:0]      wr_data_q;

  logic active;
  logic job_start;
  logic acc_ok;
  logic push;
  logic pop;
  logic ack_ok;

  // ---------------------------------------------------------------------------
  // Handshakes. acc_ok is derived from registered state only, so a pop in the
  // same cycle never frees a slot for a push. That keeps the pipeline-facing
  // ready free of any path from wr_almost_full.
  // ---------------------------------------------------------------------------
  always_comb begin
    active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    job_start = (state_q == S_IDLE) && start;
    acc_ok    = (state_q == S_RUN) &&
                (cnt_q < CNT_W'(FIFO_DEPTH)) &&
                (accepted_q < num_q);
    push      = dnn_results_vld && acc_ok;
    pop       = active && (cnt_q != '0) && !wr_almost_full;
    // An ack with nothing outstanding is a protocol violation. It is dropped so
    // that acked never runs ahead of issued.
    ack_ok    = wr_ack && active && (acked_q != issued_q);
  end

  // ---------------------------------------------------------------------------
  // Counter / pointer next state. A job start wipes everything. No push, pop or
  // ack can happen in IDLE, so the clear never collides with an increment.
  // ---------------------------------------------------------------------------
  always_comb begin
    accepted_d = accepted_q + {31'b0, push};
    issued_d   = issued_q   + {31'b0, pop};
    acked_d    = acked_q    + {31'b0, ack_ok};
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    // Push and pop together leave the occupancy unchanged.
    cnt_d      = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    if (job_start) begin
      accepted_d = '0;
      issued_d   = '0;
      acked_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
    end
  end

  // Line storage. It needs no reset because a slot is never read before it is
  // written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dnn_results;
  end

  // ---------------------------------------------------------------------------
  // FSM, counters and the registered write port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      accepted_q <= '0;
      issued_q   <= '0;
      acked_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wr_req_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      accepted_q <= accepted_d;
      issued_q   <= issued_d;
      acked_q    <= acked_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;

      // Every line is issued exactly once, so wr_req is a one-cycle strobe per
      // pop. The address wraps modulo 2^ADDR_W.
      wr_req_q <= pop;
      if (pop) begin
        wr_data_q <= mem_q[rd_ptr_q];
        wr_addr_q <= base_q + ADDR_W'(issued_q);
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            num_q   <= num_results;
            state_q <= (num_results == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accepted_q == num_q) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Compare against the post-ack count so that DONE follows the last
          // ack edge directly.
          if (acked_d == num_q) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign results_acceptable = acc_ok;
  assign wr_req             = wr_req_q;
  assign wr_addr            = wr_addr_q;
  assign wr_data            = wr_data_q;
  assign busy               = active;
  assign done               = (state_q == S_DONE);
  assign wr_count           = acked_q;

endmodule

// File: tb/tb_dnn_result_writer.sv
module tb_dnn_result_writer;
  localparam int AW = 42;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [31:0]   num_results;
  logic          dnn_results_vld;
  logic [511:0]  dnn_results;
  logic          results_acceptable;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [511:0]  wr_data;
  logic          wr_almost_full;
  logic          wr_ack;
  logic          busy;
  logic          done;
  logic [31:0]   wr_count;

  logic ack_auto = 1'b0;
  logic ack_man  = 1'b0;
  logic auto_ack = 1'b0;
  assign wr_ack = ack_auto | ack_man;

  always #5 clk = ~clk;

  dnn_result_writer #(.FIFO_DEPTH(4), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_results(num_results), .dnn_results_vld(dnn_results_vld),
    .dnn_results(dnn_results), .results_acceptable(results_acceptable),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_almost_full(wr_almost_full), .wr_ack(wr_ack), .busy(busy),
    .done(done), .wr_count(wr_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [511:0]  data;
  } wr_t;

  wr_t           sb[$];
  int            checks = 0;
  int            fails  = 0;
  int            acc_cnt = 0;
  int            wr_seen = 0;
  int            done_cnt = 0;
  logic [AW-1:0] cur_base;
  int            job_idx;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Monitor: pop the expected write for every wr_req, count accepts and done
  // pulses, and auto-ack each request on the following edge.
  always @(negedge clk) begin
    wr_t e;
    ack_auto = auto_ack && wr_req;
    if (dnn_results_vld && results_acceptable) acc_cnt++;
    if (done) done_cnt++;
    if (wr_req) begin
      wr_seen++;
      if (sb.size() == 0) chk("wr_unexpected", wr_req, 1'b0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [31:0] n);
    cur_base = b; job_idx = 0;
    start = 1'b1; base_addr = b; num_results = n;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, n != 0);
    chk("start_acc", results_acceptable, n != 0);
    chk("start_done", done, n == 0);
    @(posedge clk); #1;
  endtask

  // Stream n beats. The data is held until it is taken. Expected writes are
  // pushed at acceptance.
  task automatic stream(input int n, input int maxc);
    int sent = 0;
    int cyc = 0;
    logic take;
    wr_t e;
    dnn_results = rnd_line();
    dnn_results_vld = 1'b1;
    while (sent < n && cyc < maxc) begin
      @(negedge clk); take = results_acceptable;
      @(posedge clk); #1; cyc++;
      if (take) begin
        e.addr = cur_base + AW'(job_idx);
        e.data = dnn_results;
        sb.push_back(e);
        job_idx++; sent++;
        dnn_results = rnd_line();
      end
    end
    dnn_results_vld = 1'b0;
    chk("stream_sent", sent, n);
  endtask

  task automatic wait_done(input int n, input int maxc);
    int c = 0;
    int d0 = done_cnt;
    do begin
      @(negedge clk); c++;
    end while (!done && c < maxc);
    chk("done_seen", done, 1'b1);
    chk("done_wr_count", wr_count, n);
    chk("done_busy", busy, 1'b0);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("done_once", done_cnt - d0, 1);
    chk("idle_busy", busy, 1'b0);
    chk("sb_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1; ack_man = 1'b1;
    @(posedge clk); #1; ack_man = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_acc"},   results_acceptable, 1'b0);
    chk({tag, "_req"},   wr_req, 1'b0);
    chk({tag, "_addr"},  wr_addr, 0);
    chk({tag, "_data"},  wr_data, 0);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_done"},  done, 1'b0);
    chk({tag, "_count"}, wr_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, d0, c;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_results = '0;
    dnn_results_vld = 1'b0; dnn_results = '0; wr_almost_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1; rst = 1'b0;

    // Basic run
    auto_ack = 1'b1;
    do_start(42'h100, 3);
    stream(3, 20);
    wait_done(3, 50);

    // Back-pressure: channel held off for 20 cycles
    wr_almost_full = 1'b1;
    a0 = acc_cnt; w0 = wr_seen;
    do_start(42'h2000, 8);
    fork
      stream(8, 200);
      begin
        repeat (18) @(negedge clk);
        chk("bp_acc4", acc_cnt - a0, 4);
        chk("bp_acc_low", results_acceptable, 1'b0);
        chk("bp_no_req", wr_seen - w0, 0);
        @(posedge clk); #1; wr_almost_full = 1'b0;
      end
    join
    wait_done(8, 100);
    chk("bp_writes", wr_seen - w0, 8);

    // Zero-length job
    a0 = acc_cnt; w0 = wr_seen; d0 = done_cnt;
    do_start(42'h55, 0);
    dnn_results_vld = 1'b1;
    repeat (4) @(negedge clk);
    chk("zero_no_acc", acc_cnt - a0, 0);
    chk("zero_no_req", wr_seen - w0, 0);
    chk("zero_done1", done_cnt - d0, 1);
    @(posedge clk); #1; dnn_results_vld = 1'b0;

    // Address wrap and excess input (the channel is held so the job stays open)
    wr_almost_full = 1'b1;
    do_start({AW{1'b1}}, 2);
    stream(2, 20);
    a0 = acc_cnt;
    dnn_results_vld = 1'b1;
    repeat (5) @(negedge clk);
    chk("wrap_excess", acc_cnt - a0, 0);
    chk("wrap_acc_low", results_acceptable, 1'b0);
    @(posedge clk); #1; dnn_results_vld = 1'b0; wr_almost_full = 1'b0;
    wait_done(2, 50);

    // Reset mid-job
    auto_ack = 1'b0;
    do_start(42'h300, 5);
    w0 = wr_seen;
    stream(2, 20);
    c = 0;
    while (wr_seen < w0 + 2 && c < 20) begin @(negedge clk); c++; end
    chk("rst_issued2", wr_seen - w0, 2);
    pulse_ack();
    chk("rst_pre_count", wr_count, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    pulse_ack();
    chk("rst_stray_ack", wr_count, 0);
    sb.delete();
    @(posedge clk); #1;
    auto_ack = 1'b1;
    do_start(42'h400, 2);
    chk("rst_new_count", wr_count, 0);
    stream(2, 20);
    wait_done(2, 50);

    // Start during RUN ignored; spurious ack with nothing outstanding
    auto_ack = 1'b0;
    do_start(42'h500, 3);
    pulse_ack();
    chk("spurious_ack", wr_count, 0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 42'h999; num_results = 1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("restart_busy", busy, 1'b1);
    @(posedge clk); #1;
    auto_ack = 1'b1;
    stream(3, 30);
    wait_done(3, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
